// File: rtl/pattern_seq_pkg.sv
// Shared types for the timed bit-pattern sequencer.
// Holds the FSM state enum and the playback mode encodings.
package pattern_seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

endpackage

// File: rtl/pattern_seq_gen_step_timer.sv
// Step-period timer: counts clocks while enabled and ticks on cnt == period-1.
// Ports: clk, reset, clear (restart count), en, period (>=1), tick.
module step_timer #(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    input  logic [TIMER_W-1:0] period,
    output logic               tick
);

    logic [TIMER_W-1:0] cnt;

    // period is never zero, so period-1 cannot wrap
    assign tick = en && (cnt == period - TIMER_W'(1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/pattern_seq_gen.sv
// Timed bit-pattern sequencer: STEPS-bit pattern per channel, one step per T clocks.
// Ports: clk, reset, start/stop/mode, time_set, ctrl_set -> signal, step_idx, busy, frame_tick, done.
module pattern_seq_gen
    import pattern_seq_pkg::*;
#(
    parameter int CHANNELS = 1,
    parameter int STEPS    = 8,
    parameter int TIMER_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       mode,
    input  logic [TIMER_W-1:0]         time_set,
    input  logic [CHANNELS*STEPS-1:0]  ctrl_set,
    output logic [CHANNELS-1:0]        signal,
    output logic [$clog2(STEPS)-1:0]   step_idx,
    output logic                       busy,
    output logic                       frame_tick,
    output logic                       done
);

    localparam int SW = $clog2(STEPS);
    localparam int PW = CHANNELS * STEPS;
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [TIMER_W-1:0] period_q, period_d;
    logic [PW-1:0]      pat_q, pat_d;
    logic [SW-1:0]      step_q, step_d;
    logic [CHANNELS-1:0] signal_q, signal_d;
    logic               stop_pend_q, stop_pend_d;
    logic               frame_tick_q, frame_tick_d;
    logic               done_q, done_d;

    logic               timer_clear;
    logic               tick;
    logic               stop_any;
    logic [TIMER_W-1:0] time_eff;
    logic [SW-1:0]      step_nxt;

    // Pick the bit of every channel for one step
    function automatic logic [CHANNELS-1:0] column(
        input logic [PW-1:0] pat,
        input logic [SW-1:0] s
    );
        logic [CHANNELS-1:0] r;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            r[c] = pat[c*STEPS + int'(s)];
        end
        return r;
    endfunction

    // A zero period behaves like one clock per step
    assign time_eff = (time_set == '0) ? TIMER_W'(1) : time_set;
    assign step_nxt = step_q + SW'(1);
    // A stop arriving on the frame-end edge still ends playback
    assign stop_any = stop_pend_q | stop;

    step_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .en     (state_q == RUN),
        .period (period_q),
        .tick   (tick)
    );

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        period_d     = period_q;
        pat_d        = pat_q;
        step_d       = step_q;
        signal_d     = signal_q;
        stop_pend_d  = stop_pend_q;
        frame_tick_d = 1'b0;
        done_d       = 1'b0;
        timer_clear  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = RUN;
                    mode_d      = mode;
                    period_d    = time_eff;
                    pat_d       = ctrl_set;
                    step_d      = '0;
                    signal_d    = column(ctrl_set, '0);
                    stop_pend_d = 1'b0;
                    timer_clear = 1'b1;
                end
            end
            RUN: begin
                stop_pend_d = stop_any;
                if (tick) begin
                    if (step_q != LAST) begin
                        step_d   = step_nxt;
                        signal_d = column(pat_q, step_nxt);
                    end else begin
                        frame_tick_d = 1'b1;
                        step_d       = '0;
                        if (mode_q == MODE_ONESHOT || stop_any) begin
                            state_d     = IDLE;
                            signal_d    = '0;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else begin
                            // Shadows pick up the inputs only at frame boundaries
                            period_d = time_eff;
                            pat_d    = ctrl_set;
                            signal_d = column(ctrl_set, '0);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= MODE_ONESHOT;
            period_q     <= '0;
            pat_q        <= '0;
            step_q       <= '0;
            signal_q     <= '0;
            stop_pend_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            period_q     <= period_d;
            pat_q        <= pat_d;
            step_q       <= step_d;
            signal_q     <= signal_d;
            stop_pend_q  <= stop_pend_d;
            frame_tick_q <= frame_tick_d;
            done_q       <= done_d;
        end
    end

    assign signal     = signal_q;
    assign step_idx   = step_q;
    assign busy       = (state_q == RUN);
    assign frame_tick = frame_tick_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Scoreboard bench for pattern_seq_gen (CHANNELS=2, STEPS=8).
// Stimulus queues expected per-cycle outputs; a negedge monitor compares them.
module tb_pattern_seq_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] time_set = '0;
    logic [15:0] ctrl_set = '0;
    logic [1:0]  signal;
    logic [2:0]  step_idx;
    logic        busy;
    logic        frame_tick;
    logic        done;

    pattern_seq_gen #(
        .CHANNELS (2),
        .STEPS    (8),
        .TIMER_W  (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .time_set   (time_set),
        .ctrl_set   (ctrl_set),
        .signal     (signal),
        .step_idx   (step_idx),
        .busy       (busy),
        .frame_tick (frame_tick),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sig;
        logic [2:0] step;
        logic       busy;
        logic       ft;
        logic       done;
    } rec_t;

    rec_t exp_q[$];
    rec_t got;
    rec_t want;
    int   checks = 0;
    int   errors = 0;

    always @(negedge clk) begin
        if (busy || done || frame_tick) begin
            got = '{sig: signal, step: step_idx, busy: busy,
                    ft: frame_tick, done: done};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got sig=%b step=%0d busy=%b ft=%b done=%b",
                         got.sig, got.step, got.busy, got.ft, got.done);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got sig=%b step=%0d busy=%b ft=%b done=%b required sig=%b step=%0d busy=%b ft=%b done=%b",
                             $time, got.sig, got.step, got.busy, got.ft, got.done,
                             want.sig, want.step, want.busy, want.ft, want.done);
                end
            end
        end
    end

    // Expected records for one frame; follows=1 when a frame ended just before
    task automatic push_frame(input logic [15:0] pat, input int t,
                              input bit follows, input int limit);
        int n;
        rec_t r;
        n = 0;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < t; k++) begin
                if (n < limit) begin
                    r.sig  = {pat[8+s], pat[s]};
                    r.step = 3'(s);
                    r.busy = 1'b1;
                    r.ft   = follows && (n == 0);
                    r.done = 1'b0;
                    exp_q.push_back(r);
                end
                n++;
            end
        end
    endtask

    task automatic push_done();
        rec_t r;
        r = '{sig: 2'b00, step: 3'd0, busy: 1'b0, ft: 1'b1, done: 1'b1};
        exp_q.push_back(r);
    endtask

    task automatic start_run(input logic m, input logic [31:0] t,
                             input logic [15:0] ctrl);
        @(posedge clk);
        #1;
        mode     = m;
        time_set = t;
        ctrl_set = ctrl;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({signal, step_idx, busy, frame_tick, done} !== 8'd0) begin
            errors++;
            $display("FAIL %s got sig=%b step=%0d busy=%b ft=%b done=%b required all zero",
                     name, signal, step_idx, busy, frame_tick, done);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
        check_idle({name, "_idle_after"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish required finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle("after_reset_release");

        // One-shot T=4, ch0 0xA6 -> 0,1,1,0,0,1,0,1; start in RUN ignored
        push_frame({8'h00, 8'hA6}, 4, 1'b0, 32);
        push_done();
        start_run(1'b0, 32'd4, {8'h00, 8'hA6});
        repeat (9) @(posedge clk);
        #1;
        start    = 1'b1;
        mode     = 1'b1;
        time_set = 32'd1;
        ctrl_set = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain("oneshot_t4");

        // T=0 behaves as T=1
        push_frame({8'hC3, 8'h5A}, 1, 1'b0, 8);
        push_done();
        start_run(1'b0, 32'd0, {8'hC3, 8'h5A});
        wait_drain("oneshot_t0");

        // Restart accepted in the done cycle, zero gap
        push_frame({8'h81, 8'h7E}, 2, 1'b0, 16);
        push_done();
        push_frame({8'h55, 8'h01}, 1, 1'b0, 8);
        push_done();
        start_run(1'b0, 32'd2, {8'h81, 8'h7E});
        repeat (16) @(posedge clk);
        #1;
        time_set = 32'd1;
        ctrl_set = {8'h55, 8'h01};
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain("restart_in_done");

        // Stop in IDLE ignored, then continuous with mid-frame input change
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        push_frame({8'hF0, 8'h33}, 3, 1'b0, 24);
        push_frame({8'h0F, 8'hCC}, 2, 1'b1, 16);
        push_done();
        start_run(1'b1, 32'd3, {8'hF0, 8'h33});
        repeat (10) @(posedge clk);
        #1;
        ctrl_set = {8'h0F, 8'hCC};
        time_set = 32'd2;
        repeat (18) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_drain("cont_stop_mid");

        // Stop on the frame-end edge ends playback
        push_frame({8'h3C, 8'h96}, 1, 1'b0, 8);
        push_done();
        start_run(1'b1, 32'd1, {8'h3C, 8'h96});
        repeat (7) @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        wait_drain("stop_at_frame_end");

        // Reset mid-RUN: outputs clear, no done pulse
        push_frame({8'hFF, 8'hAA}, 2, 1'b0, 5);
        start_run(1'b1, 32'd2, {8'hFF, 8'hAA});
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_idle("reset_mid_run");
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("no_done_after_reset");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_run_pending got %0d required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_seq_gen.md
# pattern_seq_gen

Timed bit-pattern sequencer: plays a per-channel pattern of STEPS bits, one step every T clock cycles, on CHANNELS parallel outputs. Supports one-shot and continuous playback with a start/stop handshake, shadow-latched pattern and period, and frame/done status pulses. It sits in the UART/test-signal area of the design as the general-purpose generator for serial test waveforms and control strobes, replacing fixed 8-step, single-channel generators.

## Interface
Parameters:
- CHANNELS, 1, number of independent output channels
- STEPS, 8, pattern length per channel (≥ 2)
- TIMER_W, 32, width of the step-period word

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin playback; sampled only in IDLE
- stop  in  1  request end of continuous playback; sampled only in RUN
- mode  in  1  0 = one-shot, 1 = continuous; latched with start
- time_set  in  TIMER_W  step period T in clocks (0 treated as 1)
- ctrl_set  in  CHANNELS*STEPS  pattern; bit for channel c, step s = ctrl_set[c*STEPS+s]
- signal  out  CHANNELS  registered pattern outputs
- step_idx  out  $clog2(STEPS)  current step
- busy  out  1  high while in RUN
- frame_tick  out  1  one-cycle pulse at every frame end
- done  out  1  one-cycle pulse when playback returns to IDLE

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, RUN.
- IDLE, start=1: latch mode, T = max(time_set,1), pattern = ctrl_set into shadow regs; cnt=0, step=0, signal=pattern[step 0]; go RUN.
- RUN, each edge: if cnt==T-1 → cnt=0, step-end event; else cnt+1.
- Step-end, step<STEPS-1: step+1, signal=shadow pattern[new step].
- Step-end, step==STEPS-1 (frame end): frame_tick=1.
  - one-shot or stop_pending: go IDLE, signal=0, step=0, done=1, clear stop_pending.
  - continuous: reload shadow T/pattern from time_set/ctrl_set, step=0, signal=new pattern[0].
- stop=1 in RUN sets stop_pending; current frame always completes. stop in IDLE ignored; start in RUN ignored.
- Shadow regs make input changes mid-frame invisible until the next frame.
- Counter compare is on latched T (TIMER_W bits, unsigned); no wrap of cnt possible.
- Reset: state=IDLE, signal=0, step_idx=0, busy=0, frame_tick=0, done=0, cnt=0, stop_pending=0, shadows=0. Reset mid-RUN aborts with no done pulse.

## Timing
- Start accepted at edge E0: busy and signal(step 0) valid after E0 (1-cycle latency).
- Each step held exactly T cycles; frame = STEPS*T cycles.
- Frame-end edge = E0 + STEPS*T: frame_tick and (if ending) done high for the following cycle; busy low from same edge.
- Continuous: no gap between frames; step 0 of the next frame directly follows step STEPS-1.
- Earliest restart: start sampled in the cycle done is high (state IDLE) → accepted, zero-gap re-arm.
- stop and frame end on the same edge: stop takes effect (stop_pending includes the current stop).

## Structure
- Package pattern_seq_pkg: state enum (IDLE, RUN), mode constants MODE_ONESHOT=0, MODE_CONT=1.
- Sub-module step_timer: TIMER_W counter with load/clear, output tick at cnt==T-1; top holds FSM, step counter, shadows, output mux.

## Test plan
- CHANNELS=1, STEPS=8, T=4, ctrl=8'b1010_0110, one-shot: signal = 0,1,1,0,0,1,0,1 each for 4 cycles; done one cycle at E0+32; busy low after.
- T=0 → behaves as T=1: 8 bits in 8 consecutive cycles, done at E0+8.
- CHANNELS=2, continuous, T=3, change ctrl_set mid-frame: no output change until frame end; frame_tick every 24 cycles; new pattern from next frame.
- Continuous, stop pulsed at cycle 5 of frame: frame finishes to step 7, done at frame end, signal=0 after; stop in same cycle as frame end also ends playback.
- Reset asserted mid-RUN: next cycle all outputs 0, no done; start during RUN and stop during IDLE have no effect.
